// File: rtl/rd_data_buf_pkg.sv
// Shared definitions for the read-return buffer: burst-length codes, FSM states
// and the data-path beat width.
package rd_data_buf_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    BL1 = 3'd0,
    BL2 = 3'd1,
    BL4 = 3'd2,
    BL8 = 3'd3,
    BLP = 3'd4
  } bl_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Full-page wins over the fixed lengths; all selects low means a single beat.
  function automatic bl_t bl_decode(input logic b2, input logic b4,
                                    input logic b8, input logic bp);
    if (bp)      return BLP;
    else if (b8) return BL8;
    else if (b4) return BL4;
    else if (b2) return BL2;
    else         return BL1;
  endfunction

  function automatic int unsigned bl_beats(input bl_t bl, input int unsigned page_len);
    case (bl)
      BL2:     return 2;
      BL4:     return 4;
      BL8:     return 8;
      BLP:     return page_len;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/rd_data_buf_if.sv
// Host-side read-return channel between the buffer (master) and the host (slave).
interface rd_data_buf_if #(
  parameter int DATA_W = rd_data_buf_pkg::DATA_W_DEF
);
  // A beat transfers on every rising edge where h_valid and h_ready are both high;
  // while h_valid is high and h_ready low, h_data and h_last stay stable.
  logic [DATA_W-1:0] h_data;
  logic              h_valid;
  logic              h_last;
  logic              h_ready;

  modport master (output h_data, output h_valid, output h_last, input h_ready);
  modport slave  (input h_data, input h_valid, input h_last, output h_ready);
endinterface

// File: rtl/rd_fifo_core.sv
// Generic synchronous flop-based FIFO with full/empty/occupancy; a push is
// taken when not full or when a pop happens in the same cycle.
module rd_fifo_core #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/rd_data_buf.sv
// Read-return buffer: frames data-path beats into bursts, tags the final beat,
// queues them for the host and raises rd_hold before the queue can overflow.
module rd_data_buf
  import rd_data_buf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 8,
  parameter int AFULL    = 6,
  parameter int PAGE_LEN = 256
) (
  input  logic              clk,
  input  logic              rst2,
  input  logic              rd_start,
  input  logic              burst_2,
  input  logic              burst_4,
  input  logic              burst_8,
  input  logic              burst_p,
  input  logic              rd_stop,
  input  logic [DATA_W-1:0] u_data_o,
  input  logic              u_data_valid,
  rd_data_buf_if.master     host,
  output logic              rd_hold,
  output logic              busy,
  output logic              err_ovf,
  output logic              err_seq,
  input  logic              err_clr,
  output state_t            dbg_state_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = $clog2(PAGE_LEN) + 1;
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] exp_len_q;
  logic             page_q;
  logic             busy_q;
  logic             rd_hold_q;
  logic             err_ovf_q;
  logic             err_seq_q;

  logic             beat;
  logic             is_last;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             seq_err;
  logic             open_next;
  logic             stop_nobeat;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occ_d;
  logic [DATA_W:0]  rdata;
  logic [CNT_W-1:0] new_len;

  assign new_len = CNT_W'(bl_beats(bl_decode(burst_2, burst_4, burst_8, burst_p), PAGE_LEN));

  assign beat        = (state_q == ST_COLLECT) && u_data_valid;
  assign is_last     = beat && (((cnt_q + CNT_W'(1)) == exp_len_q) || (page_q && rd_stop));
  assign open_next   = is_last && rd_start;
  assign stop_nobeat = (state_q == ST_COLLECT) && !u_data_valid && rd_stop;
  assign seq_err     = ((state_q == ST_IDLE) && u_data_valid) ||
                       ((state_q == ST_COLLECT) && rd_start && !is_last);

  assign pop     = !empty && host.h_ready;
  assign push_ok = beat && (!full || pop);
  assign drop    = beat && !push_ok;
  assign occ_d   = count + CW'(push_ok) - CW'(pop);

  rd_fifo_core #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst2),
    .push_i  (beat),
    .pop_i   (host.h_ready),
    .wdata_i ({is_last, u_data_o}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      exp_len_q <= '0;
      page_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_hold_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      rd_hold_q <= (occ_d >= AFULL_CNT);

      if (err_clr) begin
        err_ovf_q <= 1'b0;
        err_seq_q <= 1'b0;
      end else begin
        if (drop)    err_ovf_q <= 1'b1;
        if (seq_err) err_seq_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (rd_start) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            exp_len_q <= new_len;
            page_q    <= burst_p;
            busy_q    <= 1'b1;
          end
        end
        ST_COLLECT: begin
          // A dropped beat still counts so the burst boundary stays aligned.
          if (beat) cnt_q <= cnt_q + CNT_W'(1);
          if (open_next) begin
            cnt_q     <= '0;
            exp_len_q <= new_len;
            page_q    <= burst_p;
          end else if (is_last || stop_nobeat) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host.h_data  = rdata[DATA_W-1:0];
  assign host.h_last  = !empty && rdata[DATA_W];
  assign host.h_valid = !empty;
  assign rd_hold      = rd_hold_q;
  assign busy         = busy_q;
  assign err_ovf      = err_ovf_q;
  assign err_seq      = err_seq_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/rd_data_buf.md
# rd_data_buf

Read-return buffer sitting directly downstream of the SDRAM/DDR data path. It captures each read beat presented with the data path's valid strobe and counts beats against the burst length latched at read issue. It tags the final beat of every burst and queues beats in a small FIFO. It presents them to the host over a valid/ready handshake and raises a hold request to the controller before the FIFO can overflow.

## Interface
Parameters:
- DATA_W, 32, width of one read beat (matches the data path's host-side data width)
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- AFULL, 6, occupancy at or above which rd_hold asserts
- PAGE_LEN, 256, beat limit for a full-page burst

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst2  in  1  reset, asynchronous, active-low
- rd_start  in  1  one-cycle pulse: read command issued; latches the burst length
- burst_2, burst_4, burst_8, burst_p  in  1 each  burst-length selects; all low means burst of 1
- rd_stop  in  1  terminates a full-page burst
- u_data_o  in  DATA_W  read beat from the data path
- u_data_valid  in  1  beat qualifier from the data path
- h_data  out  DATA_W  head-of-FIFO beat
- h_valid  out  1  FIFO non-empty
- h_last  out  1  head beat is the final beat of its burst
- h_ready  in  1  host accepts the head beat
- rd_hold  out  1  occupancy ≥ AFULL; controller must not issue rd_start
- busy  out  1  burst in collection
- err_ovf  out  1  sticky: beat arrived while the FIFO was full and was dropped
- err_seq  out  1  sticky: beat outside a burst, or rd_start mid-burst
- err_clr  in  1  clears both sticky errors

## Operation
- FSM states IDLE and COLLECT.
- IDLE → COLLECT on rd_start. At the same edge, expected beats = 1/2/4/8/PAGE_LEN and beat counter = 0. Burst-select priority: burst_p > burst_8 > burst_4 > burst_2.
- In COLLECT, each u_data_valid pushes {last, u_data_o} and increments the counter.
  - last = (counter+1 == expected), or (burst_p and rd_stop in the same cycle).
  - Pushing a last beat returns the FSM to IDLE.
- rd_stop in COLLECT with no beat: return to IDLE with no last tag; the host sees an untagged tail.
- u_data_valid in IDLE: beat dropped, err_seq set.
- rd_start in COLLECT: ignored and err_seq set. Exception: when it coincides with the last beat, it opens the next burst in the same cycle (back-to-back bursts).
- Push accepted when not full, or when a pop happens in the same cycle. Otherwise the beat is dropped and err_ovf set. A dropped beat still advances the beat counter, so burst framing is preserved.
- Pop when h_valid & h_ready.
- err_clr has priority over a same-cycle error set.
- Counter width is clog2(PAGE_LEN)+1. Pointers are clog2(DEPTH) bits and wrap naturally. Occupancy is clog2(DEPTH)+1 bits.

## Timing
- Reset: state IDLE, pointers and occupancy 0. Outputs h_valid, h_last, rd_hold, busy, err_ovf, err_seq all 0; h_data 0.
- Latency: a beat pushed at edge N is visible on h_data/h_valid after edge N (write-to-read, 1 cycle). h_data is registered from RAM/flops, with no fall-through from u_data_o.
- h_data and h_last hold stable while h_valid & !h_ready.
- rd_hold is registered from the post-update occupancy.
- busy is high the cycle after rd_start, through the edge that pushes the last beat.
- Async reset mid-burst discards the FIFO contents and the burst context immediately.

## Structure
- Shared package: burst-length encoding constants (BL1, BL2, BL4, BL8, BLP), the state enum, and the DATA_W default shared with the data path.
- One sub-module, rd_fifo_core: a generic DEPTH×(DATA_W+1) synchronous FIFO with full, empty and occupancy outputs. It is reused by the planned write-side buffer.
- Burst counter and FSM live in the top module.

## Test plan
- BL4, h_ready=1: rd_start, then 4 beats A0..A3 → h_data A0..A3 one cycle after each push; h_last only on A3; busy low after A3.
- BL8 with h_ready=0: 8 beats into DEPTH=8 → rd_hold rises when occupancy reaches 6, h_valid held; 9th spurious beat → err_seq=1, FIFO unchanged.
- Overflow: DEPTH full, h_ready=0, new burst BL2 with 2 beats → both dropped, err_ovf=1; err_clr → 0 next cycle.
- Full-page: burst_p, 5 beats, rd_stop with the 5th → h_last on the 5th only; FSM returns to IDLE.
- Back-to-back: BL2 last beat coincides with rd_start(BL1) → next single beat tagged last; err_seq stays 0.
- Async reset asserted mid-BL8 after 3 beats → all outputs 0 at once; a post-reset BL1 burst returns correctly.
